// File: rtl/ahb_pkg.sv
// Shared AHB encodings and the per-master address-phase bundle used by the
// master-to-slave fabric.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_e;

    typedef struct packed {
        logic [31:0] haddr;
        logic [1:0]  htrans;
        logic        hwrite;
        logic [2:0]  hsize;
        logic [2:0]  hburst;
        logic [3:0]  hprot;
    } ahb_aphase_t;

    // Beats in a fixed-length burst; SINGLE and undefined-length INCR give 0.
    function automatic logic [4:0] burst_len(input logic [2:0] hburst);
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  return 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  return 5'd8;
            HBURST_WRAP16, HBURST_INCR16: return 5'd16;
            default:                      return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_rr_arbiter.sv
// Round-robin next-grant selection. The master after the current grant has
// top priority and the current grant competes last; no request parks on DEFAULT_MASTER.
module ahb_rr_arbiter #(
    parameter int NUM_MASTERS    = 3,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [NUM_MASTERS-1:0] grant,
    input  logic                   en,
    output logic [NUM_MASTERS-1:0] next_grant
);

    int cur;
    int best;
    int best_d;
    logic [NUM_MASTERS-1:0] pick;

    // Distance of master i from the slot after c; c itself is farthest.
    function automatic int rr_dist(input int i, input int c);
        return (i + NUM_MASTERS - 1 - c) % NUM_MASTERS;
    endfunction

    always_comb begin
        cur    = 0;
        best   = DEFAULT_MASTER;
        best_d = NUM_MASTERS;
        pick   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant[i]) cur = i;
        end
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (req[i] && rr_dist(i, cur) < best_d) begin
                best_d = rr_dist(i, cur);
                best   = i;
            end
        end
        for (int i = 0; i < NUM_MASTERS; i++) begin
            pick[i] = (i == best);
        end
        next_grant = en ? pick : grant;
    end

endmodule

// File: rtl/ahb_m2s_arbiter.sv
// AHB master-to-slave fabric: bus arbitration, burst-aware grant hold, and the
// address / write-data multiplexers driving the shared slave-side bus.
module ahb_m2s_arbiter
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS    = 3,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [NUM_MASTERS-1:0]    HBUSREQ,
    input  logic [NUM_MASTERS-1:0]    HLOCK,
    input  logic [32*NUM_MASTERS-1:0] HADDR_M,
    input  logic [2*NUM_MASTERS-1:0]  HTRANS_M,
    input  logic [NUM_MASTERS-1:0]    HWRITE_M,
    input  logic [3*NUM_MASTERS-1:0]  HSIZE_M,
    input  logic [3*NUM_MASTERS-1:0]  HBURST_M,
    input  logic [4*NUM_MASTERS-1:0]  HPROT_M,
    input  logic [32*NUM_MASTERS-1:0] HWDATA_M,
    input  logic                      HREADY,
    input  logic [1:0]                HRESP,
    output logic [NUM_MASTERS-1:0]    HGRANT,
    output logic [1:0]                HMASTER,
    output logic                      HMASTLOCK,
    output logic [31:0]               HADDR,
    output logic [1:0]                HTRANS,
    output logic                      HWRITE,
    output logic [2:0]                HSIZE,
    output logic [2:0]                HBURST,
    output logic [3:0]                HPROT,
    output logic [31:0]               HWDATA
);

    localparam logic [1:0]             DEF_IDX = 2'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_GNT = NUM_MASTERS'(1) << DEFAULT_MASTER;

    ahb_aphase_t [NUM_MASTERS-1:0]        aphase_a;
    logic [NUM_MASTERS-1:0][31:0]         hwdata_a;
    ahb_aphase_t                          cur_ph;

    logic [NUM_MASTERS-1:0] grant_q;
    logic [NUM_MASTERS-1:0] grant_nxt;
    logic [1:0]             hmaster_q;
    logic [1:0]             dmaster_q;
    logic                   mastlock_q;
    logic [3:0]             beat_cnt;

    logic [1:0] gnt_idx;
    logic [4:0] blen;
    logic [3:0] beat_next;
    logic [3:0] beat_eff;
    logic       resp_err;
    logic       incr_hold;
    logic       hold;

    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_ph
        assign aphase_a[g] = '{
            haddr:  HADDR_M[32*g +: 32],
            htrans: HTRANS_M[2*g +: 2],
            hwrite: HWRITE_M[g],
            hsize:  HSIZE_M[3*g +: 3],
            hburst: HBURST_M[3*g +: 3],
            hprot:  HPROT_M[4*g +: 4]
        };
    end
    assign hwdata_a = HWDATA_M;

    assign cur_ph = aphase_a[hmaster_q];
    assign blen   = burst_len(cur_ph.hburst);

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) gnt_idx = 2'(i);
        end
    end

    // Beats still to be accepted after the one currently in address phase.
    always_comb begin
        beat_next = '0;
        case (cur_ph.htrans)
            HTRANS_NONSEQ: beat_next = (blen == 5'd0) ? 4'd0 : 4'(blen - 5'd1);
            HTRANS_SEQ:    beat_next = (beat_cnt == 4'd0) ? 4'd0 : beat_cnt - 4'd1;
            HTRANS_BUSY:   beat_next = beat_cnt;
            default:       beat_next = '0;
        endcase
    end

    // A non-OKAY response terminates the burst, so its remaining beats stop holding the bus.
    assign resp_err  = (HRESP != HRESP_OKAY);
    assign beat_eff  = resp_err ? 4'd0 : beat_next;
    assign incr_hold = (cur_ph.hburst == HBURST_INCR) && (cur_ph.htrans != HTRANS_IDLE)
                       && HBUSREQ[hmaster_q];
    assign hold      = HLOCK[gnt_idx] || (beat_eff >= 4'd2) || incr_hold;

    ahb_rr_arbiter #(
        .NUM_MASTERS    (NUM_MASTERS),
        .DEFAULT_MASTER (DEFAULT_MASTER)
    ) u_rr (
        .req        (HBUSREQ | HLOCK),
        .grant      (grant_q),
        .en         (HREADY && !hold),
        .next_grant (grant_nxt)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            grant_q    <= DEF_GNT;
            hmaster_q  <= DEF_IDX;
            dmaster_q  <= DEF_IDX;
            mastlock_q <= 1'b0;
            beat_cnt   <= '0;
        end else if (HREADY) begin
            grant_q    <= grant_nxt;
            hmaster_q  <= gnt_idx;
            dmaster_q  <= hmaster_q;
            mastlock_q <= HLOCK[gnt_idx];
            beat_cnt   <= beat_eff;
        end
    end

    assign HGRANT    = grant_q;
    assign HMASTER   = hmaster_q;
    assign HMASTLOCK = mastlock_q;
    assign HADDR     = cur_ph.haddr;
    assign HTRANS    = cur_ph.htrans;
    assign HWRITE    = cur_ph.hwrite;
    assign HSIZE     = cur_ph.hsize;
    assign HBURST    = cur_ph.hburst;
    assign HPROT     = cur_ph.hprot;
    assign HWDATA    = hwdata_a[dmaster_q];

endmodule

// File: tb/tb_ahb_m2s_arbiter.sv
// Bench for ahb_m2s_arbiter: directed scenarios with literal expectations,
// then random traffic, all checked every cycle against a behavioural model.
module tb_ahb_m2s_arbiter;

    localparam int N   = 3;
    localparam int DEF = 0;

    logic              HCLK;
    logic              hrst_n;
    logic [N-1:0]      busreq, lock, hwrite_m;
    logic [N-1:0][31:0] haddr_m, hwdata_m;
    logic [N-1:0][1:0] htrans_m;
    logic [N-1:0][2:0] hsize_m, hburst_m;
    logic [N-1:0][3:0] hprot_m;
    logic              hready;
    logic [1:0]        hresp;

    logic [N-1:0] HGRANT;
    logic [1:0]   HMASTER;
    logic         HMASTLOCK;
    logic [31:0]  HADDR, HWDATA;
    logic [1:0]   HTRANS;
    logic         HWRITE;
    logic [2:0]   HSIZE, HBURST;
    logic [3:0]   HPROT;

    int total = 0;
    int bad   = 0;

    ahb_m2s_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(DEF)) dut (
        .HCLK(HCLK), .HRESETn(hrst_n),
        .HBUSREQ(busreq), .HLOCK(lock),
        .HADDR_M(haddr_m), .HTRANS_M(htrans_m), .HWRITE_M(hwrite_m),
        .HSIZE_M(hsize_m), .HBURST_M(hburst_m), .HPROT_M(hprot_m),
        .HWDATA_M(hwdata_m), .HREADY(hready), .HRESP(hresp),
        .HGRANT(HGRANT), .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    logic [1:0] m_gnt  = 2'(DEF);
    logic [1:0] m_mst  = 2'(DEF);
    logic [1:0] m_dm   = 2'(DEF);
    logic       m_lock = 1'b0;
    logic [3:0] m_bc   = 4'd0;

    function automatic int fixed_beats(input logic [2:0] b);
        case (b)
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            3'd6, 3'd7: return 16;
            default:    return 0;
        endcase
    endfunction

    always @(posedge HCLK or negedge hrst_n) begin : model
        int nb;
        int len;
        logic hold, found;
        logic [1:0] ng, c;
        if (!hrst_n) begin
            m_gnt  <= 2'(DEF);
            m_mst  <= 2'(DEF);
            m_dm   <= 2'(DEF);
            m_lock <= 1'b0;
            m_bc   <= 4'd0;
        end else if (hready) begin
            len = fixed_beats(hburst_m[m_mst]);
            case (htrans_m[m_mst])
                2'b10:   nb = (len > 0) ? len - 1 : 0;
                2'b11:   nb = (m_bc > 0) ? int'(m_bc) - 1 : 0;
                2'b01:   nb = int'(m_bc);
                default: nb = 0;
            endcase
            if (hresp != 2'b00) nb = 0;
            hold = lock[m_gnt] || (nb >= 2) ||
                   (hburst_m[m_mst] == 3'd1 && htrans_m[m_mst] != 2'b00 && busreq[m_mst]);
            ng = m_gnt;
            if (!hold) begin
                ng    = 2'(DEF);
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    c = 2'((int'(m_gnt) + k) % N);
                    if (!found && (busreq[c] || lock[c])) begin
                        ng    = c;
                        found = 1'b1;
                    end
                end
            end
            m_gnt  <= ng;
            m_mst  <= m_gnt;
            m_lock <= lock[m_gnt];
            m_dm   <= m_mst;
            m_bc   <= 4'(nb);
        end
    end

    always @(negedge HCLK) begin
        chk("cyc_grant",  32'(HGRANT), 32'(1) << m_gnt);
        chk("cyc_master", 32'(HMASTER), 32'(m_mst));
        chk("cyc_mlock",  32'(HMASTLOCK), 32'(m_lock));
        chk("cyc_haddr",  HADDR, haddr_m[m_mst]);
        chk("cyc_ctrl",   32'({HTRANS, HWRITE, HSIZE, HBURST, HPROT}),
            32'({htrans_m[m_mst], hwrite_m[m_mst], hsize_m[m_mst], hburst_m[m_mst], hprot_m[m_mst]}));
        chk("cyc_hwdata", HWDATA, hwdata_m[m_dm]);
        chk("cyc_beat",   32'(dut.beat_cnt), 32'(m_bc));
    end

    // ---------------- stimulus ----------------
    task automatic all_idle();
        busreq = '0; lock = '0; hready = 1'b1; hresp = 2'b00;
        for (int m = 0; m < N; m++) begin
            htrans_m[m] = 2'b00; hburst_m[m] = 3'd0; hwrite_m[m] = 1'b0;
        end
    endtask

    initial begin
        hrst_n = 1'b0;
        for (int m = 0; m < N; m++) begin
            haddr_m[m]  = 32'h4000_0000 + 32'(m) * 32'h100;
            hwdata_m[m] = 32'hD000_0000 + 32'(m);
            hsize_m[m]  = 3'd2;
            hprot_m[m]  = 4'(m + 1);
        end
        all_idle();

        // reset with no requests
        tick(); tick();
        htrans_m[0] = 2'b01;
        #1;
        chk("rst_grant", 32'(HGRANT), 32'b001);
        chk("rst_master", 32'(HMASTER), 32'd0);
        chk("rst_trans", 32'(HTRANS), 32'b01);
        hrst_n = 1'b1;
        tick();
        chk("rel_grant", 32'(HGRANT), 32'b001);
        chk("rel_master", 32'(HMASTER), 32'd0);
        htrans_m[0] = 2'b00;
        tick();

        // M1 single write
        busreq[1] = 1'b1; htrans_m[1] = 2'b10; hwrite_m[1] = 1'b1;
        tick();
        chk("m1_grant", 32'(HGRANT), 32'b010);
        tick();
        chk("m1_master", 32'(HMASTER), 32'd1);
        chk("m1_haddr", HADDR, 32'h4000_0100);
        busreq[1] = 1'b0; htrans_m[1] = 2'b00; hwrite_m[1] = 1'b0;
        tick();
        chk("m1_hwdata", HWDATA, 32'hD000_0001);
        tick(); tick();

        // M0 INCR4 with M2 requesting throughout
        busreq[0] = 1'b1; busreq[2] = 1'b1; htrans_m[0] = 2'b10; hburst_m[0] = 3'd3;
        tick();
        chk("i4_b0_grant", 32'(HGRANT), 32'b001);
        htrans_m[0] = 2'b11; haddr_m[0] += 4;
        tick();
        chk("i4_b1_grant", 32'(HGRANT), 32'b001);
        haddr_m[0] += 4; busreq[0] = 1'b0;
        tick();
        chk("i4_grant", 32'(HGRANT), 32'b100);
        chk("i4_b3_master", 32'(HMASTER), 32'd0);
        haddr_m[0] += 4; htrans_m[2] = 2'b10;
        tick();
        chk("i4_master", 32'(HMASTER), 32'd2);
        chk("i4_noidle", 32'(HTRANS), 32'b10);
        htrans_m[0] = 2'b00; hburst_m[0] = 3'd0; busreq[2] = 1'b0;
        tick();
        htrans_m[2] = 2'b00;
        tick();

        // locked M1 with M0/M2 requesting
        busreq = 3'b111; lock[1] = 1'b1;
        for (int i = 0; i < 8 && HGRANT != 3'b010; i++) tick();
        chk("lk_grant", 32'(HGRANT), 32'b010);
        tick();
        chk("lk_mlock", 32'(HMASTLOCK), 32'd1);
        chk("lk_master", 32'(HMASTER), 32'd1);
        repeat (3) begin
            tick();
            chk("lk_hold", 32'(HGRANT), 32'b010);
        end
        lock[1] = 1'b0; busreq[1] = 1'b0;
        tick();
        chk("lk_rr", 32'(HGRANT), 32'b100);
        tick();
        chk("lk_unlock", 32'(HMASTLOCK), 32'd0);
        busreq = '0;
        tick(); tick(); tick();

        // INCR8 with three wait states mid-burst
        busreq[0] = 1'b1; busreq[2] = 1'b1; htrans_m[0] = 2'b10; hburst_m[0] = 3'd5;
        tick();
        htrans_m[0] = 2'b11;
        tick(); tick();
        hready = 1'b0;
        repeat (3) begin
            tick();
            chk("ws_master", 32'(HMASTER), 32'd0);
            chk("ws_grant", 32'(HGRANT), 32'b001);
            chk("ws_dmaster", 32'(dut.dmaster_q), 32'd0);
            chk("ws_beat", 32'(dut.beat_cnt), 32'd5);
        end
        hready = 1'b1;
        tick(); tick(); tick();
        busreq[0] = 1'b0;
        tick();
        chk("i8_grant", 32'(HGRANT), 32'b100);
        chk("i8_b7_master", 32'(HMASTER), 32'd0);
        htrans_m[2] = 2'b10;
        tick();
        chk("i8_master", 32'(HMASTER), 32'd2);
        chk("i8_noidle", 32'(HTRANS), 32'b10);
        all_idle();
        tick(); tick(); tick();

        // ERROR on beat 2 of INCR16 with M2 requesting
        busreq[0] = 1'b1; busreq[2] = 1'b1; htrans_m[0] = 2'b10; hburst_m[0] = 3'd7;
        tick();
        htrans_m[0] = 2'b11;
        tick();
        chk("er_beat_pre", 32'(dut.beat_cnt), 32'd14);
        hresp = 2'b01;
        tick();
        chk("er_beat", 32'(dut.beat_cnt), 32'd0);
        chk("er_grant", 32'(HGRANT), 32'b100);
        all_idle();
        tick(); tick();

        // random traffic, with one asynchronous reset mid-run
        for (int it = 0; it < 1500; it++) begin
            tick();
            if (it == 700) begin
                #2 hrst_n = 1'b0;
                #1;
                chk("arst_grant", 32'(HGRANT), 32'b001);
                chk("arst_hwdata", HWDATA, hwdata_m[0]);
                tick(); tick();
                hrst_n = 1'b1;
            end
            for (int m = 0; m < N; m++) begin
                busreq[m]   = 1'($urandom_range(0, 1));
                lock[m]     = ($urandom_range(0, 7) == 0);
                htrans_m[m] = 2'($urandom_range(0, 3));
                hburst_m[m] = 3'($urandom_range(0, 7));
                hwrite_m[m] = 1'($urandom_range(0, 1));
                hsize_m[m]  = 3'($urandom_range(0, 7));
                hprot_m[m]  = 4'($urandom_range(0, 15));
                haddr_m[m]  = $urandom;
                hwdata_m[m] = $urandom;
            end
            hready = ($urandom_range(0, 4) != 0);
            hresp  = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        end

        @(posedge HCLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
